// File: rtl/adc_boxcar_decimator_pkg.sv
// rtl/adc_boxcar_decimator_pkg.sv - shared constants, accumulator sizing and FSM states for the ADC stream path
package adc_stream_pkg;

  localparam int ADC_SAMPLE_W = 14;

  typedef enum logic {
    IDLE,
    ACCUM
  } decim_state_t;

  function automatic int acc_width(input int max_log2);
    return ADC_SAMPLE_W + max_log2;
  endfunction

endpackage

// File: rtl/adc_boxcar_decimator_if.sv
// rtl/adc_boxcar_decimator_if.sv - AXI-Stream style bundle with master/slave views
interface adc_boxcar_decimator_if #(
  parameter int W = 32
) ();

  logic           tvalid;
  logic [W-1:0]   tdata;
  logic [W/8-1:0] tstrb;
  logic           tlast;
  logic           tready;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);

endinterface

// File: rtl/adc_boxcar_decimator_skid.sv
// rtl/adc_boxcar_decimator_skid.sv - two-entry AXIS skid buffer carrying data and last
module axis_skid_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready
);

  logic              v0, v1, l0, l1;
  logic [DATA_W-1:0] d0, d1;
  logic              pop, push;

  // entry 1 is only ever occupied while entry 0 is, so v1 alone means full
  assign wr_ready = !v1 || rd_ready;
  assign pop      = v0 && rd_ready;
  assign push     = wr_valid && wr_ready;
  assign rd_valid = v0;
  assign rd_data  = d0;
  assign rd_last  = l0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      l0 <= 1'b0;
      l1 <= 1'b0;
      d0 <= '0;
      d1 <= '0;
    end else if (pop) begin
      if (v1) begin
        d0 <= d1;
        l0 <= l1;
        v1 <= push;
        if (push) begin
          d1 <= wr_data;
          l1 <= wr_last;
        end
      end else begin
        v0 <= push;
        if (push) begin
          d0 <= wr_data;
          l0 <= wr_last;
        end
      end
    end else if (push) begin
      if (!v0) begin
        v0 <= 1'b1;
        d0 <= wr_data;
        l0 <= wr_last;
      end else begin
        v1 <= 1'b1;
        d1 <= wr_data;
        l1 <= wr_last;
      end
    end
  end

endmodule

// File: rtl/adc_boxcar_decimator.sv
// rtl/adc_boxcar_decimator.sv - 2^k boxcar averager/decimator for the ADC stream; ADC_DECIM_ROUND_EN selects round-half-up
module adc_boxcar_decimator
  import adc_stream_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_MAX_LOG2_DECIM     = 6,
  parameter int C_FRAME_LEN_LOG2     = 10
) (
  input  logic                           S_AXIS_ACLK,
  input  logic                           S_AXIS_ARESETN,
  adc_boxcar_decimator_if.slave          s_axis,
  adc_boxcar_decimator_if.master         m_axis,
  input  logic                           decimEnable,
  input  logic [2:0]                     log2Decim,
  input  logic                           clearDrop,
  output logic                           dropStatus,
  output logic [15:0]                    dropCount
);

  localparam int ACC_W = acc_width(C_MAX_LOG2_DECIM);
  localparam int CNT_W = C_MAX_LOG2_DECIM + 1;
  localparam logic [2:0] K_MAX = 3'(C_MAX_LOG2_DECIM);

  decim_state_t state, state_next;

  logic                        en_d, rise, accept, blk_end, tready_q;
  logic [2:0]                  k;
  logic [CNT_W-1:0]            cnt;
  logic signed [ACC_W-1:0]     acc, ext, sum_q, sum_r, rnd;
  logic                        sum_valid, res_valid;
  logic signed [ADC_SAMPLE_W-1:0] res_q;
  logic [C_FRAME_LEN_LOG2-1:0] frame_cnt;
  logic                        skid_ready, push_ok, drop;
  logic                        unused_in;

  assign unused_in = &{1'b0, s_axis.tdata[C_S_AXIS_TDATA_WIDTH-1:ADC_SAMPLE_W],
                       s_axis.tstrb, s_axis.tlast};

  assign s_axis.tready = tready_q;
  assign rise    = decimEnable && !en_d;
  assign ext     = {{(ACC_W-ADC_SAMPLE_W){s_axis.tdata[ADC_SAMPLE_W-1]}}, s_axis.tdata[ADC_SAMPLE_W-1:0]};
  assign accept  = (state == ACCUM) && decimEnable && s_axis.tvalid && tready_q;
  assign blk_end = (cnt == ((CNT_W'(1) << k) - CNT_W'(1)));

`ifdef ADC_DECIM_ROUND_EN
  assign rnd = (k == 3'd0) ? '0 : (ACC_W'(1) << (k - 3'd1));
`else
  assign rnd = '0;
`endif
  assign sum_r = sum_q + rnd;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = ACCUM;
      ACCUM:   if (!decimEnable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // en_d starts high so a level held through reset does not count as a rise
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state    <= IDLE;
      en_d     <= 1'b1;
      tready_q <= 1'b0;
    end else begin
      state    <= state_next;
      en_d     <= decimEnable;
      tready_q <= 1'b1;
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      k         <= '0;
      acc       <= '0;
      cnt       <= '0;
      sum_q     <= '0;
      sum_valid <= 1'b0;
      res_q     <= '0;
      res_valid <= 1'b0;
    end else begin
      sum_valid <= accept && blk_end;
      res_valid <= sum_valid;
      res_q     <= ADC_SAMPLE_W'(sum_r >>> k);
      if (state == IDLE && rise) begin
        k   <= (log2Decim > K_MAX) ? K_MAX : log2Decim;
        acc <= '0;
        cnt <= '0;
      end else if (state == ACCUM && !decimEnable) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        if (blk_end) begin
          sum_q <= acc + ext;
          acc   <= '0;
          cnt   <= '0;
        end else begin
          acc <= acc + ext;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign push_ok = res_valid && skid_ready;
  assign drop    = res_valid && !skid_ready;

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      frame_cnt  <= '0;
      dropStatus <= 1'b0;
      dropCount  <= '0;
    end else begin
      if (rise)
        frame_cnt <= '0;
      else if (push_ok)
        frame_cnt <= frame_cnt + 1'b1;
      if (clearDrop) begin
        dropStatus <= 1'b0;
        dropCount  <= '0;
      end else if (drop) begin
        dropStatus <= 1'b1;
        if (dropCount != 16'hFFFF)
          dropCount <= dropCount + 16'd1;
      end
    end
  end

  axis_skid_buffer #(.DATA_W(C_M_AXIS_TDATA_WIDTH)) u_skid (
    .clk      (S_AXIS_ACLK),
    .rst_n    (S_AXIS_ARESETN),
    .wr_valid (res_valid),
    .wr_data  ({{(C_M_AXIS_TDATA_WIDTH-ADC_SAMPLE_W){res_q[ADC_SAMPLE_W-1]}}, res_q}),
    .wr_last  (&frame_cnt),
    .wr_ready (skid_ready),
    .rd_valid (m_axis.tvalid),
    .rd_data  (m_axis.tdata),
    .rd_last  (m_axis.tlast),
    .rd_ready (m_axis.tready)
  );

  assign m_axis.tstrb = '1;

endmodule

// File: tb/tb_adc_boxcar_decimator.sv
// tb/tb_adc_boxcar_decimator.sv - randomized bench for adc_boxcar_decimator against a block-average reference model
module tb_adc_boxcar_decimator;

  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        decimEnable = 1'b0;
  logic [2:0]  log2Decim = 3'd0;
  logic        clearDrop = 1'b0;
  logic        dropStatus;
  logic [15:0] dropCount;

  always #5 clk = ~clk;

  adc_boxcar_decimator_if #(.W(32)) s_axis ();
  adc_boxcar_decimator_if #(.W(32)) m_axis ();

  adc_boxcar_decimator #(
    .C_S_AXIS_TDATA_WIDTH (32),
    .C_M_AXIS_TDATA_WIDTH (32),
    .C_MAX_LOG2_DECIM     (6),
    .C_FRAME_LEN_LOG2     (4)
  ) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .s_axis         (s_axis),
    .m_axis         (m_axis),
    .decimEnable    (decimEnable),
    .log2Decim      (log2Decim),
    .clearDrop      (clearDrop),
    .dropStatus     (dropStatus),
    .dropCount      (dropCount)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q[$];
  int          smp[$];
  int          beat_idx = 0;
  int          n_extra = 0;
  int          n_last = 0;
  bit          mon_en = 1'b0;
  bit          rand_ready = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // floor(sum / 2^k), optionally biased by half an LSB first
  function automatic int ref_avg(input longint sum_in, input int kk);
    longint d, s, q;
    d = longint'(1) << kk;
    s = sum_in;
`ifdef ADC_DECIM_ROUND_EN
    if (kk > 0) s = s + d / 2;
`endif
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return int'(q);
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  task automatic step();
    logic [32:0] e;
    @(negedge clk);
    if (mon_en && m_axis.tvalid && m_axis.tready) begin
      if (exp_q.size() == 0) n_extra++;
      else begin
        e = exp_q.pop_front();
        check("beat_data", m_axis.tdata, e[31:0]);
        check("beat_last", m_axis.tlast, e[32]);
        if (m_axis.tlast) n_last++;
      end
    end
    @(posedge clk);
    #1;
    if (rand_ready) m_axis.tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive(input int v);
    logic [31:0] w;
    w = $urandom;
    w[13:0] = v[13:0];
    s_axis.tdata = w;
    s_axis.tvalid = 1'b1;
  endtask

  task automatic send(input int v);
    int n;
    drive(v);
    n = 0;
    while (!s_axis.tready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) check("s_tready_timeout", 0, 1);
    step();
    s_axis.tvalid = 1'b0;
  endtask

  task automatic enable(input int kraw);
    decimEnable = 1'b0;
    step();
    log2Decim = 3'(kraw);
    decimEnable = 1'b1;
    step();
    beat_idx = 0;
  endtask

  task automatic send_samples(input int keff, input bit gaps);
    int     d, v, r;
    longint sum;
    logic   lst;
    d = 1 << keff;
    while (smp.size() >= d) begin
      sum = 0;
      for (int i = 0; i < d; i++) begin
        v = smp.pop_front();
        sum += v;
        send(v);
        if (gaps) repeat ($urandom_range(0, 1)) step();
      end
      r = ref_avg(sum, keff);
      lst = ((beat_idx % FRAME) == FRAME - 1);
      exp_q.push_back({lst, 32'(r)});
      beat_idx++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      step();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (4) step();
  endtask

  initial begin
    int s0, s1, kraw, keff, nb;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tstrb  = '0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", s_axis.tready, 0);
    check("rst_m_tvalid", m_axis.tvalid, 0);
    check("rst_m_tdata", m_axis.tdata, 0);
    check("rst_m_tlast", m_axis.tlast, 0);
    check("rst_drop_status", dropStatus, 0);
    check("rst_drop_count", dropCount, 0);
    rst_n = 1'b1;
    step();
    check("s_tready_after_release", s_axis.tready, 1);
    mon_en = 1'b1;

    enable(2);
    smp = '{4, 8, 12, 16, 1, 2, 2, 2};
    send_samples(2, 1'b0);
    drain();

    // k=0 latency: each result appears two edges after its sample is taken
    mon_en = 1'b0;
    enable(0);
    drive(-5);
    step();
    drive(3);
    step();
    s_axis.tvalid = 1'b0;
    check("lat_edge1_valid", m_axis.tvalid, 0);
    step();
    check("lat_edge2_valid", m_axis.tvalid, 1);
    check("lat_edge2_data", m_axis.tdata, 32'hFFFFFFFB);
    check("m_tstrb", m_axis.tstrb, 4'hF);
    step();
    check("lat_edge3_valid", m_axis.tvalid, 1);
    check("lat_edge3_data", m_axis.tdata, 3);
    step();
    check("lat_edge4_valid", m_axis.tvalid, 0);
    mon_en = 1'b1;

    enable(0);
    m_axis.tready = 1'b0;
    s0 = rnd_sample();
    s1 = rnd_sample();
    send(s0);
    send(s1);
    repeat (3) send(rnd_sample());
    repeat (4) step();
    check("drop_count", dropCount, 3);
    check("drop_status", dropStatus, 1);
    check("held_valid", m_axis.tvalid, 1);
    check("held_data", m_axis.tdata, 32'(s0));
    clearDrop = 1'b1;
    step();
    clearDrop = 1'b0;
    check("drop_count_cleared", dropCount, 0);
    check("drop_status_cleared", dropStatus, 0);
    exp_q.push_back({1'b0, 32'(s0)});
    exp_q.push_back({1'b0, 32'(s1)});
    beat_idx = 2;
    m_axis.tready = 1'b1;
    drain();

    enable(1);
    n_last = 0;
    repeat (64) smp.push_back(rnd_sample());
    send_samples(1, 1'b1);
    drain();
    check("frame_last_count", n_last, 2);

    enable(6);
    repeat (64) smp.push_back(8191);
    send_samples(6, 1'b0);
    drain();
    enable(7);
    repeat (64) smp.push_back(-8192);
    send_samples(6, 1'b0);
    drain();

    for (int r = 0; r < 10; r++) begin
      kraw = int'($urandom_range(0, 7));
      keff = (kraw > 6) ? 6 : kraw;
      enable(kraw);
      nb = (keff >= 4) ? 2 : int'($urandom_range(2, 8));
      repeat (nb << keff) smp.push_back(rnd_sample());
      rand_ready = (keff >= 2);
      send_samples(keff, 1'b1);
      rand_ready = 1'b0;
      m_axis.tready = 1'b1;
      drain();
    end
    check("no_drops_random", dropCount, 0);

    // async reset with a held beat and a partial block in flight
    m_axis.tready = 1'b0;
    enable(0);
    send(1234);
    repeat (2) step();
    enable(2);
    repeat (3) send(rnd_sample());
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_m_tvalid", m_axis.tvalid, 0);
    check("async_rst_m_tdata", m_axis.tdata, 0);
    check("async_rst_s_tready", s_axis.tready, 0);
    step();
    rst_n = 1'b1;
    decimEnable = 1'b0;
    m_axis.tready = 1'b1;
    step();
    enable(2);
    smp = '{100, 200, 300, 400};
    send_samples(2, 1'b0);
    drain();
    check("extra_beats", n_extra, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
